// File: rtl/poly_voice_allocator_pkg.sv
// ============================================================================
// Module : voice_pkg
// Brief  : Shared defaults and index/rank types for the polyphonic allocator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package voice_pkg;

   localparam int NUM_KEYS_DEF   = 12;
   localparam int NUM_VOICES_DEF = 3;

   typedef logic [$clog2(NUM_KEYS_DEF)-1:0]     key_idx_t;
   typedef logic [$clog2(NUM_VOICES_DEF+1)-1:0] rank_t;

endpackage

`default_nettype wire

// File: rtl/poly_voice_allocator_key_sync.sv
// ============================================================================
// Module : key_sync
// Brief  : Parametrised-width two-flop synchroniser for raw key switches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_sync #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/poly_voice_allocator.sv
// ============================================================================
// Module : poly_voice_allocator
// Brief  : Assigns held keys to voices, frees on release, optionally steals oldest.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module poly_voice_allocator
   import voice_pkg::*;
#(
   parameter int NUM_KEYS   = NUM_KEYS_DEF,
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   parameter int STEAL_EN   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_KEYS-1:0]            switches,
   output logic [NUM_VOICES*NUM_KEYS-1:0] note_out,
   output logic [NUM_VOICES-1:0]          voice_active,
   output logic [NUM_VOICES-1:0]          note_on,
   output logic                           steal
);

   localparam int c_KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int c_VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int c_RW = $clog2(NUM_VOICES + 1);

   logic [NUM_KEYS-1:0]            w_keys_s;

   logic [c_KW-1:0]                r_owner [NUM_VOICES];
   logic [NUM_VOICES-1:0]          r_active;
   logic [c_RW-1:0]                r_rank  [NUM_VOICES];
   logic [NUM_KEYS-1:0]            r_dropped;
   logic [NUM_VOICES*NUM_KEYS-1:0] r_note_out;
   logic [NUM_VOICES-1:0]          r_note_on;
   logic                           r_steal;

   logic [NUM_KEYS-1:0]            w_owner_hot [NUM_VOICES];
   logic [NUM_VOICES-1:0]          w_release;
   logic [NUM_KEYS-1:0]            w_assigned;
   logic [NUM_KEYS-1:0]            w_pending;
   logic [NUM_KEYS-1:0]            w_new_note;
   logic [NUM_KEYS-1:0]            w_steal_mask;
   logic [NUM_KEYS-1:0]            w_dropped_next;
   logic                           w_pend_any;
   logic [c_KW-1:0]                w_pend_idx;
   logic                           w_free_any;
   logic [c_VW-1:0]                w_free_idx;
   logic [c_VW-1:0]                w_victim_idx;
   logic [c_RW-1:0]                w_victim_rank;
   logic [c_VW-1:0]                w_target;
   logic                           w_alloc;
   logic                           w_steal;
   logic [NUM_VOICES-1:0]          w_vacate;
   logic [c_RW-1:0]                w_rank_next [NUM_VOICES];

   key_sync #(
      .WIDTH (NUM_KEYS)
   ) u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (switches),
      .q     (w_keys_s)
   );

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            w_owner_hot[v][k] = (r_owner[v] == c_KW'(k));
         end
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_release
      assign w_release[v] = r_active[v] & ~|(w_owner_hot[v] & w_keys_s);
   end

   always_comb begin
      w_assigned = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (r_active[v]) w_assigned = w_assigned | w_owner_hot[v];
      end
      w_pending = w_keys_s & ~w_assigned & ~r_dropped;
   end

   // Lowest-index pending key and lowest-index free voice
   always_comb begin
      w_pend_any = |w_pending;
      w_pend_idx = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (w_pending[k]) w_pend_idx = c_KW'(k);
      end
      w_free_any = ~&r_active;
      w_free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!r_active[v]) w_free_idx = c_VW'(v);
      end
   end

   always_comb begin
      w_victim_idx  = '0;
      w_victim_rank = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (r_active[v] && (r_rank[v] >= w_victim_rank)) begin
            w_victim_idx  = c_VW'(v);
            w_victim_rank = r_rank[v];
         end
      end
   end

   // Free voices come from registered state only; a voice releasing now is not reusable yet
   assign w_alloc  = w_pend_any & (w_free_any | (STEAL_EN != 0));
   assign w_steal  = w_alloc & ~w_free_any;
   assign w_target = w_free_any ? w_free_idx : w_victim_idx;

   always_comb begin
      w_steal_mask = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         w_vacate[v] = w_release[v] | (w_steal & (w_target == c_VW'(v)));
         if (w_steal && (w_target == c_VW'(v))) w_steal_mask = w_steal_mask | w_owner_hot[v];
      end
      w_dropped_next = (r_dropped | w_steal_mask) & w_keys_s;
   end

   always_comb begin
      w_new_note = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (w_pend_idx == c_KW'(k)) w_new_note[NUM_KEYS-1-k] = 1'b1;
      end
   end

   // Survivors close the gaps left by vacated younger voices, then age by one on allocation
   always_comb begin
      logic [c_RW-1:0] w_cnt;
      for (int v = 0; v < NUM_VOICES; v++) begin
         w_cnt = '0;
         for (int u = 0; u < NUM_VOICES; u++) begin
            if (w_vacate[u] && (r_rank[u] < r_rank[v])) w_cnt = w_cnt + c_RW'(1);
         end
         w_rank_next[v] = r_rank[v] - w_cnt + c_RW'(w_alloc);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_owner[v] <= '0;
            r_rank[v]  <= '0;
         end
         r_active   <= '0;
         r_dropped  <= '0;
         r_note_out <= '0;
         r_note_on  <= '0;
         r_steal    <= 1'b0;
      end else begin
         r_note_on <= '0;
         r_steal   <= w_steal;
         r_dropped <= w_dropped_next;
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_alloc && (w_target == c_VW'(v))) begin
               r_owner[v]                         <= w_pend_idx;
               r_active[v]                        <= 1'b1;
               r_rank[v]                          <= '0;
               r_note_out[v*NUM_KEYS +: NUM_KEYS] <= w_new_note;
               r_note_on[v]                       <= 1'b1;
            end else if (w_release[v]) begin
               r_owner[v]                         <= '0;
               r_active[v]                        <= 1'b0;
               r_rank[v]                          <= '0;
               r_note_out[v*NUM_KEYS +: NUM_KEYS] <= '0;
            end else if (r_active[v]) begin
               r_rank[v] <= w_rank_next[v];
            end
         end
      end
   end

   assign note_out     = r_note_out;
   assign voice_active = r_active;
   assign note_on      = r_note_on;
   assign steal        = r_steal;

endmodule

`default_nettype wire
